// File: rtl/uart_rx_capture.sv
// 8N1 UART receiver that captures bytes from an idle-high serial line into a
// small byte FIFO drained through a valid/ready port.
module uart_rx_capture #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        rx_i,
  output logic [7:0]                  data_o,
  output logic                        valid_o,
  input  logic                        ready_i,
  output logic [$clog2(FIFO_DEPTH):0] count_o,
  output logic                        frame_err_o,
  output logic                        overflow_o
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);

  localparam logic [BAUD_W-1:0] HALF_M1 = BAUD_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BAUD_W-1:0] FULL_M1 = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [PTR_W:0]    DEPTH_C = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_e;

  // Synchronizer and previous-sample flops idle high so reset never looks
  // like a start edge.
  logic rx_meta_q, rx_s_q, rx_prev_q;

  state_e            state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [7:0]        shift_q, shift_d;

  logic [PTR_W:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]    rd_ptr_q, rd_ptr_d;
  logic [7:0]        mem_q [FIFO_DEPTH];
  logic [7:0]        mem_d [FIFO_DEPTH];
  logic              frame_err_q, frame_err_d;
  logic              overflow_q, overflow_d;

  logic              good_stop, bad_stop;
  logic              push, pop, full;
  logic [PTR_W:0]    count;

  // NOTE: sequential state always uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx_i;
      rx_s_q    <= rx_meta_q;
      rx_prev_q <= rx_s_q;
    end
  end

  // NOTE: every signal written here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q + BAUD_W'(1);
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    good_stop = 1'b0;
    bad_stop  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        baud_d = '0;
        if (rx_prev_q && !rx_s_q) state_d = S_START;
      end
      S_START: begin
        if (baud_q == HALF_M1) begin
          if (!rx_s_q) begin
            state_d   = S_DATA;
            bit_idx_d = '0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (baud_q == FULL_M1) begin
          shift_d[bit_idx_q] = rx_s_q;
          baud_d             = '0;
          if (bit_idx_q == 3'd7) state_d = S_STOP;
          else                   bit_idx_d = bit_idx_q + 3'd1;
        end
      end
      S_STOP: begin
        if (baud_q == FULL_M1) begin
          if (rx_s_q) begin
            good_stop = 1'b1;
            state_d   = S_IDLE;
          end else begin
            bad_stop = 1'b1;
            state_d  = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        baud_d = '0;
        if (rx_s_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d != state_q) baud_d = '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
    end
  end

  // Pointer difference with wrap bits gives occupancy 0..FIFO_DEPTH directly.
  assign count = wr_ptr_q - rd_ptr_q;
  assign full  = (count == DEPTH_C);
  assign pop   = valid_o & ready_i;
  assign push  = good_stop & (~full | pop);

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    mem_d       = mem_q;
    frame_err_d = bad_stop;
    overflow_d  = good_stop & ~push;
    if (push) begin
      mem_d[wr_ptr_q[PTR_W-1:0]] = shift_q;
      wr_ptr_d = wr_ptr_q + (PTR_W + 1)'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + (PTR_W + 1)'(1);
  end

  // NOTE: the storage array is reset so data_o reads a defined 0 out of reset;
  // at this depth a resettable register file costs nothing noteworthy.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      frame_err_q <= frame_err_d;
      overflow_q  <= overflow_d;
      mem_q       <= mem_d;
    end
  end

  assign data_o      = mem_q[rd_ptr_q[PTR_W-1:0]];
  assign valid_o     = (count != '0);
  assign count_o     = count;
  assign frame_err_o = frame_err_q;
  assign overflow_o  = overflow_q;

endmodule

// File: doc/uart_rx_capture.md
# uart_rx_capture

FPGA-side UART receiver that listens to the MCU's `uart_tx_o` line and collects each transmitted byte into a small FIFO. Host-side logic drains the FIFO through a valid/ready port. The block sits beside `x_heep_system` in the FPGA top, runs in the `clk_gen` domain, and lets on-board logic capture console output without an external USB-UART bridge. Frame format is fixed at 8N1, LSB first, idle high.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 868: clock cycles per UART bit. Must be ≥ 8.
- `FIFO_DEPTH`, default 16: byte FIFO depth. Must be a power of 2 and ≥ 2.

Ports:
- `clk_i` input 1: block clock.
- `rst_ni` input 1: reset. One clock; reset is asynchronous and active-low.
- `rx_i` input 1: serial line, asynchronous to `clk_i`, idle high.
- `data_o` output 8: byte at the FIFO head.
- `valid_o` output 1: FIFO not empty.
- `ready_i` input 1: consumer accepts the head byte. A pop occurs when `valid_o & ready_i`.
- `count_o` output `$clog2(FIFO_DEPTH)+1`: current FIFO occupancy.
- `frame_err_o` output 1: one-cycle pulse on a bad stop bit.
- `overflow_o` output 1: one-cycle pulse when a good byte is dropped because the FIFO is full.

## Operation
Input synchronizer:
- Two-flop synchronizer on `rx_i`; both flops reset to 1.
- All logic below uses the synchronized signal `rx_s`.

Bit counter and baud counter:
- Baud counter width is `$clog2(CLKS_PER_BIT)`. It reloads to 0 on every state change.
- Bit index is 3 bits wide.

FSM states, reset state IDLE:
- IDLE:
  - Falling edge of `rx_s` (previous 1, current 0) → START, baud counter cleared.
- START:
  - When the baud counter reaches `CLKS_PER_BIT/2 - 1` (integer division), sample `rx_s`.
  - If 0 → DATA, bit index 0.
  - If 1 → IDLE (glitch rejected, nothing else happens).
- DATA:
  - When the baud counter reaches `CLKS_PER_BIT - 1`, sample `rx_s` into the shift register at the current bit index (LSB first).
  - After bit index 7 → STOP.
- STOP:
  - When the baud counter reaches `CLKS_PER_BIT - 1`, sample `rx_s`.
  - If 1: push the byte (or drop it if the FIFO is full, see below), then → IDLE.
  - If 0: pulse `frame_err_o`, discard the byte, → BREAK.
- BREAK:
  - Wait for `rx_s == 1`, then → IDLE. Line-low breaks produce only one `frame_err_o`.

FIFO:
- Circular buffer with read and write pointers of width `$clog2(FIFO_DEPTH)` plus one wrap bit each.
- `count_o` = write pointer − read pointer, including wrap bits.
- Push condition: a good stop bit and (`count_o < FIFO_DEPTH` or a pop happens in the same cycle).
- Otherwise a good byte is dropped and `overflow_o` pulses. Existing contents are never overwritten.
- Simultaneous push and pop: both take effect and `count_o` is unchanged.
- Pop when empty is impossible because `valid_o` is 0.
- `data_o` shows the storage entry at the read pointer. Its value is don't-care when `valid_o` is 0.

Reset:
- Reset asserted mid-frame or with a non-empty FIFO returns the FSM to IDLE and empties the FIFO.
- All outputs go to their reset values asynchronously.

## Timing
Reset values:
- `valid_o` = 0, `count_o` = 0, `frame_err_o` = 0, `overflow_o` = 0.
- `data_o` = 0, since the storage entries are reset to 0.

Latency:
- `rx_i` edge to `rx_s`: 2 cycles.
- Start-bit falling edge on `rx_s` to stop-bit sample: `CLKS_PER_BIT/2 + 9*CLKS_PER_BIT` cycles, to within ±1 cycle.
- Stop-bit sample cycle to `valid_o`, `count_o` and `data_o` update: 1 cycle (registered).
- `frame_err_o` and `overflow_o` are registered and asserted in the same cycle `count_o` would have updated.
- Pop: `count_o` and `data_o` update on the clock edge where `valid_o & ready_i` is true.

Throughput:
- Back-to-back frames are supported. After the STOP sample the FSM is in IDLE one cycle later, well before the next start edge.

## Test plan
Use `CLKS_PER_BIT=16` and `FIFO_DEPTH=4` for all scenarios.
- Single byte: send 0xA5 at 16 cycles per bit with `ready_i=0` → `valid_o=1`, `data_o=0xA5`, `count_o=1`, no error pulses. Then `ready_i=1` for 1 cycle → `valid_o=0`, `count_o=0`.
- Back-to-back frames: send 0x00, 0xFF, 0x55 with no idle gap, then drain → the bytes come out in that order.
- Overflow: with `ready_i=0`, send 5 bytes 0x01..0x05 → `count_o=4`, exactly one `overflow_o` pulse on byte 5, and draining yields 0x01..0x04.
- Full with concurrent pop: FIFO holds 4 bytes, hold `ready_i=1` across the stop-bit cycle of byte 0x66 → no overflow, `count_o` stays 4, and 0x66 is last out.
- Framing error and glitch: send 0x3C with the stop bit held at 0 for 40 cycles → one `frame_err_o` pulse, `count_o` unchanged, and a following 0x81 is received correctly. Separately, a 4-cycle low glitch on an idle line produces no byte and no error.
- Reset mid-frame: assert `rst_ni=0` during DATA bit 4 with 2 bytes queued → `count_o=0` and `valid_o=0` immediately. A fresh 0x7E after reset is received correctly.
